// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit shared types: memory-op and writeback records,
// access-size and FSM state enums, widths and a size helper.
package mem_access_unit_pkg;

  localparam int cXLEN       = 32;
  localparam int cRegSelBitW = 5;
  localparam int cByteEnW    = cXLEN / 8;

  typedef enum logic [2:0] {
    eByte  = 3'b000,
    eHalf  = 3'b001,
    eWord  = 3'b010,
    eByteU = 3'b100,
    eHalfU = 3'b101
  } tMemSize;

  typedef enum logic [1:0] {
    eIdle,
    eReq,
    eResp
  } tMemState;

  typedef struct packed {
    logic                   read;
    logic                   write;
    logic [cXLEN-1:0]       addr;
    logic [cXLEN-1:0]       data;
    logic [2:0]             opType;
    logic [cRegSelBitW-1:0] rdAddr;
  } tMemOp;

  typedef struct packed {
    logic                   dv;
    logic [cRegSelBitW-1:0] addr;
    logic [cXLEN-1:0]       data;
  } tRegOp;

  // 0 = byte, 1 = half, 2 = word; reserved codes act as word.
  function automatic logic [1:0] f_width(input logic [2:0] t);
    logic [1:0] w;
    case (t)
      eByte, eByteU: w = 2'd0;
      eHalf, eHalfU: w = 2'd1;
      default:       w = 2'd2;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and memory (slave).
// Ports: oMemReq/oMemWe/oMemAddr/oMemBe/oMemWdata out, iMemGnt/iMemRvalid/iMemRdata in.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic                oMemReq;
  logic                oMemWe;
  logic [cXLEN-1:0]    oMemAddr;
  logic [cByteEnW-1:0] oMemBe;
  logic [cXLEN-1:0]    oMemWdata;
  logic                iMemGnt;
  logic                iMemRvalid;
  logic [cXLEN-1:0]    iMemRdata;

  modport master (
    output oMemReq, oMemWe, oMemAddr, oMemBe, oMemWdata,
    input  iMemGnt, iMemRvalid, iMemRdata
  );

  modport slave (
    input  oMemReq, oMemWe, oMemAddr, oMemBe, oMemWdata,
    output iMemGnt, iMemRvalid, iMemRdata
  );

endinterface

// File: rtl/mem_access_unit_align.sv
// load_store_align: combinational byte-lane logic for the memory stage.
// In: i_op_type, i_off, i_st_data, i_ld_word. Out: o_be, o_wdata, o_ld_data.
module load_store_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]          i_op_type,
  input  logic [1:0]          i_off,
  input  logic [cXLEN-1:0]    i_st_data,
  input  logic [cXLEN-1:0]    i_ld_word,
  output logic [cByteEnW-1:0] o_be,
  output logic [cXLEN-1:0]    o_wdata,
  output logic [cXLEN-1:0]    o_ld_data
);

  logic [1:0]       w_width;
  logic [3:0]       w_be_half;
  logic [cXLEN-1:0] w_rot;

  assign w_width = f_width(i_op_type);

  // Halfword lanes wrap inside the word at offset 3.
  always_comb begin
    w_be_half = 4'b0011;
    unique case (i_off)
      2'd0: w_be_half = 4'b0011;
      2'd1: w_be_half = 4'b0110;
      2'd2: w_be_half = 4'b1100;
      2'd3: w_be_half = 4'b1001;
    endcase
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_data;
    unique case (w_width)
      2'd0: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      2'd1: begin
        o_be    = w_be_half;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
      end
    endcase
  end

  // Rotate the selected lane down to bit 0.
  always_comb begin
    w_rot = i_ld_word;
    unique case (i_off)
      2'd0: w_rot = i_ld_word;
      2'd1: w_rot = {i_ld_word[7:0],  i_ld_word[31:8]};
      2'd2: w_rot = {i_ld_word[15:0], i_ld_word[31:16]};
      2'd3: w_rot = {i_ld_word[23:0], i_ld_word[31:24]};
    endcase
  end

  always_comb begin
    o_ld_data = i_ld_word;
    case (i_op_type)
      eByte:   o_ld_data = {{24{w_rot[7]}}, w_rot[7:0]};
      eHalf:   o_ld_data = {{16{w_rot[15]}}, w_rot[15:0]};
      eByteU:  o_ld_data = {24'd0, w_rot[7:0]};
      eHalfU:  o_ld_data = {16'd0, w_rot[15:0]};
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage, single-outstanding bus, load extension.
// Ports: clk, rst, iValid, iMemOp, iRegOp, oStall, oRegOp, oMisalign, bus.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned half/word instead of issuing.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                iValid,
  input  tMemOp               iMemOp,
  input  tRegOp               iRegOp,
  output logic                oStall,
  output tRegOp               oRegOp,
  output logic                oMisalign,
  mem_access_unit_if.master   bus
);

  tMemState            r_state;
  tMemState            w_next;
  tMemOp               r_op;
  tRegOp               r_reg_op;
  logic                w_is_mem;
  logic                w_idle;
  logic                w_misal;
  logic                w_wb;
  logic                w_req;
  logic [cByteEnW-1:0] w_be;
  logic [cXLEN-1:0]    w_wdata;
  logic [cXLEN-1:0]    w_ld_data;

  assign w_idle   = (r_state == eIdle);
  assign w_is_mem = iValid & (iMemOp.read | iMemOp.write);

`ifdef MEM_MISALIGN_TRAP_EN
  logic [1:0] w_width;
  logic       r_misalign;

  assign w_width = f_width(iMemOp.opType);
  assign w_misal = ((w_width == 2'd1) & iMemOp.addr[0]) |
                   ((w_width == 2'd2) & (iMemOp.addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_idle & w_is_mem & w_misal;
  end

  assign oMisalign = r_misalign;
`else
  assign w_misal   = 1'b0;
  assign oMisalign = 1'b0;
`endif

  load_store_align u_align (
    .i_op_type (r_op.opType),
    .i_off     (r_op.addr[1:0]),
    .i_st_data (r_op.data),
    .i_ld_word (bus.iMemRdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_ld_data (w_ld_data)
  );

  always_comb begin
    w_next = r_state;
    w_wb   = 1'b0;
    unique case (r_state)
      eIdle: begin
        if (w_is_mem && !w_misal) w_next = eReq;
      end
      eReq: begin
        if (bus.iMemGnt) begin
          if (r_op.write) begin
            w_next = eIdle;
          end else if (bus.iMemRvalid) begin
            w_wb   = r_op.read;
            w_next = eIdle;
          end else begin
            w_next = eResp;
          end
        end
      end
      eResp: begin
        if (bus.iMemRvalid) begin
          w_wb   = 1'b1;
          w_next = eIdle;
        end
      end
      default: w_next = eIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= eIdle;
      r_op     <= '0;
      r_reg_op <= '0;
    end else begin
      r_state  <= w_next;
      r_reg_op <= '0;
      if (w_idle && iValid) begin
        if (!w_is_mem)     r_reg_op <= iRegOp;
        else if (!w_misal) r_op     <= iMemOp;
      end
      if (w_wb) begin
        r_reg_op <= '{dv:   (r_op.rdAddr != '0),
                      addr: r_op.rdAddr,
                      data: w_ld_data};
      end
    end
  end

  assign w_req         = (r_state == eReq);
  assign oStall        = !w_idle;
  assign oRegOp        = r_reg_op;
  assign bus.oMemReq   = w_req;
  assign bus.oMemWe    = w_req & r_op.write;
  assign bus.oMemAddr  = w_req ? {r_op.addr[cXLEN-1:2], 2'b00} : '0;
  assign bus.oMemBe    = w_req ? w_be : '0;
  assign bus.oMemWdata = w_req ? w_wdata : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit
// against an arithmetic model of lanes, extension and latency.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  iValid = 1'b0;
  tMemOp iMemOp = '0;
  tRegOp iRegOp = '0;
  logic  oStall;
  logic  oMisalign;
  tRegOp oRegOp;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk       (clk),
    .rst       (rst),
    .iValid    (iValid),
    .iMemOp    (iMemOp),
    .iRegOp    (iRegOp),
    .oStall    (oStall),
    .oRegOp    (oRegOp),
    .oMisalign (oMisalign),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          c_first_req;
  int          c_done;
  logic        c_seen_req;
  logic        c_we;
  logic        c_misal;
  logic        c_req_after;
  logic        c_unstable;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;
  tRegOp       c_wb;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int m_width(input logic [2:0] t);
    if (t == 3'b000 || t == 3'b100) return 0;
    if (t == 3'b001 || t == 3'b101) return 1;
    return 2;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] t,
                                      input logic [1:0] off);
    int v;
    if (m_width(t) == 0) return 4'(1 << off);
    if (m_width(t) == 1) begin
      v = 3 << off;
      return 4'((v | (v >> 4)) & 15);
    end
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] t,
                                          input logic [31:0] d);
    if (m_width(t) == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (m_width(t) == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] t,
                                         input logic [1:0] off,
                                         input logic [31:0] w);
    logic [63:0] dbl;
    logic [31:0] lane;
    dbl  = {w, w} >> (8 * off);
    lane = dbl[31:0];
    case (t)
      3'b000: return (lane & 32'h80) != 0 ?
                     (lane & 32'hFF) | 32'hFFFF_FF00 : lane & 32'hFF;
      3'b001: return (lane & 32'h8000) != 0 ?
                     (lane & 32'hFFFF) | 32'hFFFF_0000 : lane & 32'hFFFF;
      3'b100: return lane & 32'hFF;
      3'b101: return lane & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic bit m_misal(input logic [2:0] t,
                                 input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (m_width(t) == 1 && a[0]) return 1;
    if (m_width(t) == 2 && a[1:0] != 2'b00) return 1;
`endif
    return 0;
  endfunction

  // ---------------- drivers (no comparisons) ----------------
  task automatic run_mem(input tMemOp op, input int gd, input int rdl,
                         input logic [31:0] rdata, input bit noise);
    int   k;
    int   gcyc;
    bit   granted;
    c_first_req = -1;
    c_done      = -1;
    c_seen_req  = 0;
    c_misal     = 0;
    c_unstable  = 0;
    c_req_after = 0;
    c_we = 0; c_addr = 0; c_be = 0; c_wdata = 0; c_wb = '0;
    k = 0; gcyc = 0; granted = 0;
    iValid = 1'b1;
    iMemOp = op;
    iRegOp = '{dv: 1'b1, addr: 5'd3, data: $urandom};
    tick;
    for (int cyc = 1; cyc < 60; cyc++) begin
      if (oMisalign) c_misal = 1;
      if (!oStall) begin
        c_done      = cyc;
        c_wb        = oRegOp;
        c_req_after = bus.oMemReq;
        break;
      end
      bus.iMemGnt    = 1'b0;
      bus.iMemRvalid = 1'b0;
      if (!granted && bus.oMemReq) begin
        if (!c_seen_req) begin
          c_first_req = cyc;
          c_we    = bus.oMemWe;
          c_addr  = bus.oMemAddr;
          c_be    = bus.oMemBe;
          c_wdata = bus.oMemWdata;
        end else if (bus.oMemAddr !== c_addr || bus.oMemBe !== c_be ||
                     bus.oMemWdata !== c_wdata || bus.oMemWe !== c_we) begin
          c_unstable = 1;
        end
        c_seen_req = 1;
        if (k == gd) begin
          bus.iMemGnt = 1'b1;
          granted = 1;
          gcyc = cyc;
          if (!op.write && rdl == 0) begin
            bus.iMemRvalid = 1'b1;
            bus.iMemRdata  = rdata;
          end
        end else if (noise) begin
          bus.iMemRvalid = 1'b1;
          bus.iMemRdata  = ~rdata;
        end
        k++;
      end else if (granted && (cyc - gcyc) == rdl) begin
        bus.iMemRvalid = 1'b1;
        bus.iMemRdata  = rdata;
      end
      iValid = noise;
      iMemOp = '{read: 1'b1, write: 1'b0, addr: $urandom,
                 data: $urandom, opType: 3'b010, rdAddr: 5'd1};
      tick;
    end
    iValid = 1'b0;
    bus.iMemGnt = 1'b0;
    bus.iMemRvalid = 1'b0;
  endtask

  function automatic tMemOp mk(input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] t, input logic [4:0] r);
    tMemOp o;
    o = '{read: rd, write: wr, addr: a, data: d, opType: t, rdAddr: r};
    return o;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    iValid = 1'b1;
    iMemOp = mk(1, 0, 32'h40, 32'h0, 3'b010, 5'd4);
    tick;
    tick;
    checks++;
    if (oStall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=0", oStall);
    end
    checks++;
    if (bus.oMemReq !== 1'b0 || bus.oMemWe !== 1'b0) begin
      failures++;
      $display("FAIL reset_req got=%b%b exp=00", bus.oMemReq, bus.oMemWe);
    end
    checks++;
    if (bus.oMemAddr !== 32'h0 || bus.oMemBe !== 4'h0 ||
        bus.oMemWdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h/%h/%h exp=0/0/0",
               bus.oMemAddr, bus.oMemBe, bus.oMemWdata);
    end
    checks++;
    if (oRegOp !== '0 || oMisalign !== 1'b0) begin
      failures++;
      $display("FAIL reset_regop got=%h/%b exp=0/0", oRegOp, oMisalign);
    end
    iValid = 1'b0;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_lw_zero_wait;
    run_mem(mk(1, 0, 32'h100, 32'h0, 3'b010, 5'd5), 0, 0, 32'hDEADBEEF, 0);
    checks++;
    if (c_first_req !== 1 || c_we !== 1'b0 || c_addr !== 32'h100 ||
        c_be !== 4'hF) begin
      failures++;
      $display("FAIL lw_req got=%0d/%b/%h/%h exp=1/0/100/f",
               c_first_req, c_we, c_addr, c_be);
    end
    checks++;
    if (c_done !== 2) begin
      failures++;
      $display("FAIL lw_latency got=%0d exp=2", c_done);
    end
    checks++;
    if (c_wb !== tRegOp'{dv: 1'b1, addr: 5'd5, data: 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL lw_wb got=%h exp=%h", c_wb,
               tRegOp'{dv: 1'b1, addr: 5'd5, data: 32'hDEADBEEF});
    end
  endtask

  task automatic test_lb_delayed;
    run_mem(mk(1, 0, 32'h103, 32'h0, 3'b000, 5'd6), 2, 3, 32'h80FFFFFF, 1);
    checks++;
    if (c_done !== 7 || c_unstable !== 1'b0) begin
      failures++;
      $display("FAIL lb_latency got=%0d/%b exp=7/0", c_done, c_unstable);
    end
    checks++;
    if (c_wb.dv !== 1'b1 || c_wb.data !== 32'hFFFFFF80) begin
      failures++;
      $display("FAIL lb_data got=%b/%h exp=1/ffffff80", c_wb.dv, c_wb.data);
    end
    run_mem(mk(1, 0, 32'h103, 32'h0, 3'b100, 5'd6), 2, 3, 32'h80FFFFFF, 1);
    checks++;
    if (c_wb.dv !== 1'b1 || c_wb.data !== 32'h00000080) begin
      failures++;
      $display("FAIL lbu_data got=%b/%h exp=1/00000080", c_wb.dv, c_wb.data);
    end
  endtask

  task automatic test_sh;
    run_mem(mk(0, 1, 32'h102, 32'h1234ABCD, 3'b001, 5'd9), 0, 0, 32'h0, 0);
    checks++;
    if (c_we !== 1'b1 || c_addr !== 32'h100 || c_be !== 4'b1100 ||
        c_wdata !== 32'hABCDABCD) begin
      failures++;
      $display("FAIL sh_bus got=%b/%h/%b/%h exp=1/100/1100/abcdabcd",
               c_we, c_addr, c_be, c_wdata);
    end
    checks++;
    if (c_wb.dv !== 1'b0 || c_done !== 2 || c_req_after !== 1'b0) begin
      failures++;
      $display("FAIL sh_done got=%b/%0d/%b exp=0/2/0",
               c_wb.dv, c_done, c_req_after);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    d = $urandom;
    iValid = 1'b1;
    iMemOp = mk(0, 0, $urandom, $urandom, 3'b010, 5'd2);
    iRegOp = '{dv: 1'b1, addr: 5'd7, data: 32'h55};
    tick;
    checks++;
    if (oRegOp !== tRegOp'{dv: 1'b1, addr: 5'd7, data: 32'h55} ||
        oStall !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pass got=%h/%b exp=%h/0", oRegOp, oStall,
               tRegOp'{dv: 1'b1, addr: 5'd7, data: 32'h55});
    end
    run_mem(mk(0, 1, 32'h8, d, 3'b010, 5'd0), 1, 0, 32'h0, 0);
    checks++;
    if (c_first_req !== 1 || c_be !== 4'hF || c_addr !== 32'h8 ||
        c_wdata !== d || c_we !== 1'b1) begin
      failures++;
      $display("FAIL b2b_sw got=%0d/%h/%h/%h exp=1/f/8/%h",
               c_first_req, c_be, c_addr, c_wdata, d);
    end
  endtask

  task automatic test_rst_mid;
    iValid = 1'b1;
    iMemOp = mk(1, 0, 32'h200, 32'h0, 3'b010, 5'd12);
    tick;
    iValid = 1'b0;
    bus.iMemGnt = bus.oMemReq;
    tick;
    bus.iMemGnt = 1'b0;
    checks++;
    if (oStall !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_wait got=%b exp=1", oStall);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (oStall !== 1'b0 || bus.oMemReq !== 1'b0 || bus.oMemAddr !== 32'h0 ||
        bus.oMemBe !== 4'h0 || oRegOp !== '0) begin
      failures++;
      $display("FAIL rstmid_clear got=%b/%b/%h/%h/%h exp=0/0/0/0/0",
               oStall, bus.oMemReq, bus.oMemAddr, bus.oMemBe, oRegOp);
    end
    tick;
    bus.iMemRvalid = 1'b1;
    bus.iMemRdata  = 32'hCAFEF00D;
    tick;
    bus.iMemRvalid = 1'b0;
    checks++;
    if (oRegOp.dv !== 1'b0 || oStall !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_stale got=%b/%b exp=0/0", oRegOp.dv, oStall);
    end
    tick;
    checks++;
    if (oRegOp.dv !== 1'b0 || bus.oMemReq !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after got=%b/%b exp=0/0", oRegOp.dv, bus.oMemReq);
    end
  endtask

  task automatic test_misalign;
    logic [31:0] w;
    w = $urandom;
    run_mem(mk(1, 0, 32'h101, 32'h0, 3'b010, 5'd9), 0, 0, w, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if (c_misal !== 1'b1 || c_seen_req !== 1'b0 || c_done !== 1 ||
        c_wb.dv !== 1'b0) begin
      failures++;
      $display("FAIL misalign_trap got=%b/%b/%0d/%b exp=1/0/1/0",
               c_misal, c_seen_req, c_done, c_wb.dv);
    end
`else
    checks++;
    if (c_misal !== 1'b0 || c_addr !== 32'h100 || c_done !== 2 ||
        c_wb !== tRegOp'{dv: 1'b1, addr: 5'd9, data: w}) begin
      failures++;
      $display("FAIL misalign_load got=%b/%h/%0d/%h exp=0/100/2/%h",
               c_misal, c_addr, c_done, c_wb,
               tRegOp'{dv: 1'b1, addr: 5'd9, data: w});
    end
`endif
  endtask

  task automatic test_random;
    tMemOp       op;
    tRegOp       ro;
    logic [31:0] w;
    int          gd;
    int          rdl;
    int          lat;
    int          rw;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ro = '{dv: 1'($urandom), addr: 5'($urandom), data: $urandom};
        iValid = 1'b1;
        iMemOp = mk(0, 0, $urandom, $urandom, 3'($urandom), 5'($urandom));
        iRegOp = ro;
        tick;
        iValid = 1'b0;
        checks++;
        if (oRegOp !== ro || oStall !== 1'b0) begin
          failures++;
          $display("FAIL rnd_pass n=%0d got=%h/%b exp=%h/0",
                   n, oRegOp, oStall, ro);
        end
        continue;
      end
      rw  = $urandom_range(1, 3);
      op  = mk(rw[0], rw[1], $urandom, $urandom,
               3'($urandom_range(0, 7)), 5'($urandom));
      gd  = $urandom_range(0, 3);
      rdl = $urandom_range(0, 3);
      w   = $urandom;
      run_mem(op, gd, rdl, w, 1'($urandom));
      if (m_misal(op.opType, op.addr)) begin
        checks++;
        if (c_misal !== 1'b1 || c_seen_req !== 1'b0 || c_done !== 1 ||
            c_wb.dv !== 1'b0) begin
          failures++;
          $display("FAIL rnd_trap n=%0d got=%b/%b/%0d/%b exp=1/0/1/0",
                   n, c_misal, c_seen_req, c_done, c_wb.dv);
        end
        continue;
      end
      lat = 2 + gd + (op.write ? 0 : rdl);
      checks++;
      if (c_first_req !== 1 || c_done !== lat || c_unstable !== 1'b0 ||
          c_misal !== 1'b0) begin
        failures++;
        $display("FAIL rnd_timing n=%0d got=%0d/%0d/%b/%b exp=1/%0d/0/0",
                 n, c_first_req, c_done, c_unstable, c_misal, lat);
      end
      checks++;
      if (c_we !== op.write || c_addr !== (op.addr & 32'hFFFF_FFFC) ||
          c_be !== m_be(op.opType, op.addr[1:0])) begin
        failures++;
        $display("FAIL rnd_bus n=%0d got=%b/%h/%h exp=%b/%h/%h", n,
                 c_we, c_addr, c_be, op.write,
                 op.addr & 32'hFFFF_FFFC, m_be(op.opType, op.addr[1:0]));
      end
      if (op.write) begin
        checks++;
        if (c_wdata !== m_wdata(op.opType, op.data) || c_wb.dv !== 1'b0) begin
          failures++;
          $display("FAIL rnd_store n=%0d got=%h/%b exp=%h/0", n,
                   c_wdata, c_wb.dv, m_wdata(op.opType, op.data));
        end
      end else if (op.rdAddr == 5'd0) begin
        checks++;
        if (c_wb.dv !== 1'b0) begin
          failures++;
          $display("FAIL rnd_x0 n=%0d got=%b exp=0", n, c_wb.dv);
        end
      end else begin
        checks++;
        if (c_wb.dv !== 1'b1 || c_wb.addr !== op.rdAddr ||
            c_wb.data !== m_load(op.opType, op.addr[1:0], w)) begin
          failures++;
          $display("FAIL rnd_load n=%0d t=%b off=%0d got=%h exp=1/%h/%h",
                   n, op.opType, op.addr[1:0], c_wb, op.rdAddr,
                   m_load(op.opType, op.addr[1:0], w));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iMemGnt    = 1'b0;
    bus.iMemRvalid = 1'b0;
    bus.iMemRdata  = '0;
    test_reset();
    test_lw_zero_wait();
    test_lb_delayed();
    test_sh();
    test_back_to_back();
    test_rst_mid();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage responder for the ALU's memory-operation record. It accepts the `tMemOp`/`tRegOp` pair produced at the ALU output, drives a single-outstanding data-memory bus with byte-lane alignment, and sign- or zero-extends load data. It returns a `tRegOp` writeback record to the register file and stalls the pipeline while a bus transaction is in flight. Non-memory register ops pass through with matched latency.

## Interface
- `cXLEN`, 32: data/address width; byte-enable width is cXLEN/8.
- `cRegSelBitW`, 5: register address width.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `iValid` input 1: `iMemOp`/`iRegOp` valid this cycle.
- `iMemOp` input tMemOp: read/write/addr/data/opType(funct3)/rdAddr.
- `iRegOp` input tRegOp: ALU writeback record for non-memory ops.
- `oStall` output 1: unit busy; upstream must hold inputs.
- `oMemReq` output 1: bus request.
- `oMemWe` output 1: 1 = store.
- `oMemAddr` output cXLEN: word-aligned address (low 2 bits 0).
- `oMemBe` output cXLEN/8: byte enables.
- `oMemWdata` output cXLEN: lane-shifted store data.
- `iMemGnt` input 1: request accepted.
- `iMemRvalid` input 1: load data valid.
- `iMemRdata` input cXLEN: load word.
- `oRegOp` output tRegOp: writeback (dv/addr/data).
- `oMisalign` output 1: misaligned-access pulse (only with macro; otherwise tied 0).

## Operation
- FSM states: eIdle, eReq, eResp.
- eIdle: on `iValid & (read|write)`, latch op and go to eReq. On `iValid` with neither flag set, register `iRegOp` to `oRegOp` next cycle.
- eReq: `oMemReq=1` with stable addr/we/be/wdata. On `iMemGnt`:
  - Store: return to eIdle.
  - Load with `iMemRvalid` in the same cycle: complete and go to eIdle.
  - Load otherwise: go to eResp.
  - `iMemRvalid` without `iMemGnt` is ignored.
- eResp: wait for `iMemRvalid`, then go to eIdle and emit writeback.
- Load writeback:
  - `oRegOp.dv=1` for one cycle, `addr=rdAddr`, `data` = extended lane of `iMemRdata` selected by addr[1:0].
  - opType 000 LB sign-extends, 001 LH sign-extends, 010 LW, 100 LBU zero-extends, 101 LHU zero-extends.
  - rdAddr=0: the read is still performed and `dv=0`.
- Stores:
  - SB: be = 1<<addr[1:0], data replicated ×4.
  - SH: be = 0011<<addr[1:0], data replicated ×2.
  - SW: be = 1111.
  - `oRegOp.dv=0`.
- Reserved opType values (011, 110, 111) are treated as a word access.
- `oStall = (state != eIdle)`. Inputs are ignored while stalled.
- `iRead & iWrite` together: the store wins.
- `iMemRvalid` is ignored in eIdle and eReq-without-gnt, so stale responses are dropped.

## Timing
- Reset values: state eIdle, `oStall=0`, `oMemReq=0`, `oMemWe=0`, `oMemAddr=0`, `oMemBe=0`, `oMemWdata=0`, `oRegOp=0`, `oMisalign=0`.
- Pass-through op: `oRegOp` valid 1 cycle after acceptance.
- Memory op: `oMemReq` asserted the cycle after acceptance. It is held until gnt and drops the cycle after gnt.
- Load with zero-wait memory (gnt and rvalid in the first eReq cycle): writeback 2 cycles after acceptance. Each wait cycle adds 1.
- `oStall` rises the cycle after acceptance and falls the cycle writeback/store completion registers. The next op can be accepted that same cycle.
- `rst` mid-transaction: next edge forces eIdle and all outputs to reset values. The pending op is discarded and a later `iMemRvalid` is ignored.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are detected at acceptance: half with addr[0]=1, or word with addr[1:0]≠0.
  - Such an access issues no bus request and leaves `oStall` low.
  - `oMisalign` pulses 1 cycle after acceptance and `oRegOp.dv=0`.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - No check is made; the address is aligned down and lanes computed from addr[1:0] as normal.
  - A halfword at offset 3 wraps its lanes within the word.
  - `oMisalign` is constant 0.

## Structure
- corePckg additions:
  - `tMemSize` enum: eByte=000, eHalf=001, eWord=010, eByteU=100, eHalfU=101.
  - `tMemState` enum: eIdle, eReq, eResp.
  - constant `cByteEnW = cXLEN/8`.
- Sub-module `load_store_align` (combinational): store lane shift and byte enables, load lane select and extension. Both directions are unit-testable in isolation.

## Test plan
- LW addr 0x100, gnt+rvalid same cycle, rdata 0xDEADBEEF, rd=5 -> req 1 cycle after accept; `oRegOp={1,5,0xDEADBEEF}` 2 cycles after accept.
- LB addr 0x103, rdata 0x80FFFFFF, gnt delayed 2 cycles, rvalid 3 cycles later -> `data=0xFFFFFF80`; LBU gives 0x00000080; `oStall` high the whole time.
- SH addr 0x102, data 0x1234ABCD -> `be=1100`, `wdata=0xABCDABCD`, `oMemAddr=0x100`, `oRegOp.dv=0`.
- Back-to-back: pass-through regOp {1,7,0x55}, then SW addr 0x8 -> `oRegOp` 0x55 after 1 cycle; store issued next cycle with `be=1111`.
- `rst` in eResp, then `iMemRvalid` 2 cycles later -> all outputs 0, no writeback.
- LW addr 0x101: with `MEM_MISALIGN_TRAP_EN`, `oMisalign` pulse and no `oMemReq`; without it, `oMemAddr=0x100` and a normal load.
